// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the data-memory init loader.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE
  } state_e;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int LANES          = 4;
  localparam int LANE_W         = $clog2(LANES);
  localparam int WORD_W         = LANES * 8;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/mem_init_loader_if.sv
// Byte-stream input and data-memory init write port of the loader.
interface mem_init_loader_if
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  // Byte stream: one byte moves on every rising edge where byte_valid & byte_ready;
  // the source holds byte_data stable while byte_valid is high and ready is low.
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              init_write_enable;
  logic [ADDR_W-1:0] init_addr;
  logic [WORD_W-1:0] init_data;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, init_write_enable, init_addr, init_data
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, init_write_enable, init_addr, init_data
  );
endinterface

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word shift assembler with a lane counter.
module loader_word_assembler
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);
  logic [WORD_W-1:0] word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  // Bytes enter at the top and drift down, so the first byte lands in [7:0].
  assign word_next = {byte_in, word_q[WORD_W-1:8]};
  assign word_full = (lane_q == LANE_W'(LANES - 1));

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (clear) begin
      word_d = '0;
      lane_d = '0;
    end else if (shift_en) begin
      word_d = word_next;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end
endmodule

// File: rtl/mem_init_loader.sv
// Loads data memory from a framed byte stream (count, LE words, XOR checksum)
// and holds the CPU in reset until a load ends with a good checksum.
module mem_init_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  mem_init_loader_if.slave  bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_e            state_dbg
);
  state_e              state_q, state_d;
  logic [7:0]          n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     idx_inc;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                asm_clear, asm_shift, asm_full, accept;
  logic [WORD_W-1:0]   asm_word_next;

  loader_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (bus.byte_data),
    .word_next (asm_word_next),
    .word_full (asm_full)
  );

  assign bus.byte_ready = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign busy           = bus.byte_ready || (state_q == ST_WRITE);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign idx_inc        = {1'b0, idx_q} + (ADDR_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    error_d   = error_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_COUNT;
          idx_d     = '0;
          csum_d    = '0;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          asm_clear = 1'b1;
        end
      end
      ST_COUNT: begin
        if (accept) begin
          n_d     = bus.byte_data;
          state_d = (bus.byte_data != 8'd0) ? ST_DATA : ST_CSUM;
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_shift = 1'b1;
          csum_d    = csum_q ^ bus.byte_data;
          if (asm_full) begin
            // Strobe and payload are registered here so the write lands one cycle later.
            we_d    = 1'b1;
            addr_d  = idx_q;
            data_d  = asm_word_next;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc[ADDR_W-1:0];
        state_d = (idx_inc == (ADDR_W + 1)'(n_q)) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (accept) begin
          done_d  = 1'b1;
          error_d = (bus.byte_data != csum_q);
          hold_d  = (bus.byte_data != csum_q);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.init_write_enable = we_q;
  assign bus.init_addr         = addr_q;
  assign bus.init_data         = data_q;
  assign cpu_hold              = hold_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign state_dbg             = state_q;
endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader with a write scoreboard.
module tb_mem_init_loader;
  import mem_loader_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   cpu_hold, busy, done, error;
  state_e state_dbg;

  mem_init_loader_if #(.ADDR_W(8)) bus ();

  mem_init_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] FRAME [9] = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                                       8'hEF, 8'hBE, 8'hAD, 8'hDE};

  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  logic [7:0]  good_csum;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.init_write_enable === 1'b1) begin
      n_writes++;
      chk("write_stall_ready", {39'd0, bus.byte_ready}, 40'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus.init_addr, bus.init_data}, 40'hFF_FFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {bus.init_addr, bus.init_data}, e);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit accepted;
    gap = $urandom_range(max_gap, 0);
    accepted = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) chk("byte_accept_timeout", 40'd0, 40'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_good();
    exp_q.push_back({8'h00, 32'h12345678});
    exp_q.push_back({8'h01, 32'hDEADBEEF});
  endtask

  task automatic send_std(input logic [7:0] csum, input int max_gap, input bit mid_start);
    for (int i = 0; i < 9; i++) begin
      if (mid_start && i == 4) begin
        pulse_start();
        chk("start_while_busy_state", 40'(state_dbg), 40'(ST_DATA));
        chk("start_while_busy_busy", {39'd0, busy}, 40'd1);
      end
      send_byte(FRAME[i], max_gap);
    end
    send_byte(csum, max_gap);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_hold"}, {39'd0, cpu_hold}, 40'd1);
    chk({tag, "_byte_ready"}, {39'd0, bus.byte_ready}, 40'd0);
    chk({tag, "_we"}, {39'd0, bus.init_write_enable}, 40'd0);
    chk({tag, "_busy"}, {39'd0, busy}, 40'd0);
    chk({tag, "_done"}, {39'd0, done}, 40'd0);
    chk({tag, "_error"}, {39'd0, error}, 40'd0);
    chk({tag, "_addr_data"}, {bus.init_addr, bus.init_data}, 40'd0);
    chk({tag, "_state"}, 40'(state_dbg), 40'(ST_IDLE));
  endtask

  task automatic check_end(input string tag, input logic exp_err, input int exp_writes);
    chk({tag, "_done"}, {39'd0, done}, 40'd1);
    chk({tag, "_error"}, {39'd0, error}, {39'd0, exp_err});
    chk({tag, "_cpu_hold"}, {39'd0, cpu_hold}, {39'd0, exp_err});
    chk({tag, "_busy"}, {39'd0, busy}, 40'd0);
    chk({tag, "_writes"}, 40'(n_writes), 40'(exp_writes));
    chk({tag, "_sb_empty"}, 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    good_csum = 8'h00;
    for (int i = 1; i < 9; i++) good_csum = good_csum ^ FRAME[i];
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);

    // Good load, continuous source
    expect_good();
    n_writes = 0;
    pulse_start();
    chk("start_busy", {39'd0, busy}, 40'd1);
    chk("start_state", 40'(state_dbg), 40'(ST_COUNT));
    send_std(good_csum, 0, 1'b0);
    check_end("good", 1'b0, 2);

    // Bad checksum
    expect_good();
    n_writes = 0;
    pulse_start();
    chk("restart_done_clr", {39'd0, done}, 40'd0);
    chk("restart_hold", {39'd0, cpu_hold}, 40'd1);
    send_std(8'h00, 0, 1'b0);
    check_end("bad", 1'b1, 2);

    // Reset while idle in DONE with stale outputs
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("idle_rst");
    reset = 1'b1;
    @(negedge clk);

    // Empty load
    n_writes = 0;
    pulse_start();
    send_byte(8'h00, 0);
    chk("empty_state", 40'(state_dbg), 40'(ST_CSUM));
    send_byte(8'h00, 0);
    check_end("empty", 1'b0, 0);

    // Bytes offered in DONE must be ignored
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("done_ignore_state", 40'(state_dbg), 40'(ST_DONE));
    chk("done_ignore_flags", {37'd0, done, error, cpu_hold}, 40'b100);

    // Random gaps plus a start pulse while busy
    expect_good();
    n_writes = 0;
    pulse_start();
    send_std(good_csum, 3, 1'b1);
    check_end("gaps", 1'b0, 2);

    // Reset in the middle of the first word
    n_writes = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_state", 40'(state_dbg), 40'(ST_IDLE));
    chk("midrst_hold", {39'd0, cpu_hold}, 40'd1);
    chk("midrst_writes", 40'(n_writes), 40'd0);
    reset = 1'b1;
    @(negedge clk);
    expect_good();
    pulse_start();
    send_std(good_csum, 1, 1'b0);
    check_end("after_midrst", 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_init_loader.md
# mem_init_loader

Byte-stream loader that fills the processor's data memory through its data-memory init write port before the program runs. It receives a framed byte stream: word count, little-endian data words, XOR checksum. It emits one init write per assembled word and holds the processor in reset until a load completes with a good checksum. It sits between a host byte source (UART receiver or testbench) and the datapath's `data_init_write_enable` / `data_init_addr` / `data_init_data` inputs.

## Interface
- `ADDR_W`, 8, init address width; matches `data_init_addr`.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `byte_valid`  input  1  source has a byte on `byte_data`.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader accepts the byte this cycle; a transfer occurs when `byte_valid & byte_ready`.
- `init_write_enable`  output  1  one-cycle write strobe to data memory.
- `init_addr`  output  ADDR_W  word address of the write.
- `init_data`  output  32  assembled word.
- `cpu_hold`  output  1  high holds the processor in reset.
- `busy`  output  1  load in progress.
- `done`  output  1  sticky; the last load finished, whether the checksum was good or bad.
- `error`  output  1  sticky; the last load had a checksum mismatch.

## Operation
- **Frame format:** byte 0 is N, the word count (0–255). Then 4·N data bytes, little-endian per word: the first byte is bits [7:0]. The final byte is the checksum, equal to the XOR of all data bytes. The count byte is excluded from the checksum.
- **States:** IDLE, COUNT, DATA, WRITE, CSUM, DONE.
  - IDLE → COUNT on `start`.
  - COUNT: accept one byte and latch it as N. Then go to DATA if N≠0, otherwise CSUM.
  - DATA: accept bytes into the shift assembler and XOR each into the running checksum. After the 4th byte of a word, go to WRITE.
  - WRITE: assert `init_write_enable` with `init_addr` = word index and `init_data` = the assembled word. Then increment the word index. Go to CSUM if the index reaches N, otherwise DATA.
  - CSUM: accept one byte and compare it with the running checksum. Go to DONE and set `done`. Set `error` on mismatch.
  - DONE: `cpu_hold` = `error`. `start` → COUNT; this clears `done`, `error`, the checksum, the word index and the byte counter, and sets `cpu_hold` = 1.
- **`byte_ready`:** 1 exactly in COUNT, DATA and CSUM.
- **`busy`:** 1 in COUNT, DATA, WRITE and CSUM.
- **`start` while busy:** ignored.
- **`byte_valid` outside the accepting states:** ignored; no byte is consumed.
- **Width rules:**
  - The word index is ADDR_W bits; N ≤ 255 guarantees no wrap.
  - The byte-within-word counter is 2 bits.
  - The checksum is 8 bits.
- **Reset (any time, including mid-load):**
  - State goes to IDLE.
  - Word index, byte counter and checksum go to 0.
  - Memory words already written are not undone.

## Timing
- **Reset values:**
  - `cpu_hold` = 1.
  - `byte_ready`, `init_write_enable`, `busy`, `done`, `error` = 0.
  - `init_addr` = 0, `init_data` = 0.
- **Write latency:** `init_write_enable` is high in the cycle after the 4th byte of a word is accepted, for exactly one cycle. It is registered, not combinational from `byte_valid`.
- **Write-cycle stall:** `byte_ready` = 0 during the WRITE cycle. The source must hold its byte.
- **Throughput:** at most 5 cycles per word with a continuous source.
- **Completion:** `done`/`error` update, and `cpu_hold` falls (good checksum), in the cycle after the checksum byte is accepted.
- **Outputs:** all outputs are registered, except `byte_ready` and `busy`, which decode directly from state.

## Structure
- **Package `mem_loader_pkg`:**
  - the state enum;
  - the `ADDR_W` default;
  - byte-lane count 4;
  - checksum width 8.
- **Sub-module `loader_word_assembler`:**
  - a 32-bit shift register;
  - shift-in strobe and byte input;
  - a 2-bit lane counter with a `word_full` flag;
  - a clear input.
- **Top module:** the FSM, word index, checksum, and output registers.

## Test plan
- **Reset:** assert `reset` = 0 mid-idle. Then `cpu_hold` = 1; `byte_ready`, `init_write_enable`, `busy`, `done`, `error`, `init_addr` and `init_data` all = 0.
- **Good load:** `start`, then bytes 02, 78 56 34 12, EF BE AD DE, 2A. Required response:
  - write addr 0x00 = 0x12345678, then addr 0x01 = 0xDEADBEEF;
  - `done` = 1, `error` = 0, `cpu_hold` = 0.
- **Bad checksum:** the same stream with final byte 00. Both writes occur; then `done` = 1, `error` = 1, `cpu_hold` stays 1.
- **Empty load:** `start`, bytes 00, 00. No `init_write_enable` pulse; `done` = 1, `error` = 0, `cpu_hold` = 0.
- **Backpressure and gaps:**
  - random `byte_valid` gaps: the data written must be identical to the good load;
  - `byte_ready` = 0 in each WRITE cycle, with no byte lost or duplicated;
  - `start` pulsed while busy has no effect.
- **Reset mid-load:** assert reset after 02, 78, 56. Then state IDLE, `cpu_hold` = 1, no write. A following full good load writes addr 0 = 0x12345678 with no leftover lane data.
